seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Display scheduler for the 4-digit seven-segment display in the pong game.
- Takes the two binary player scores and converts each to two BCD digits with a sequential double-dabble.
- Holds the result in a display buffer and time-multiplexes the four digits onto the BCD decoder's tog/num inputs at a fixed refresh rate.
- Sits between the score logic and the BCD decoder; the decoder's anode and segment outputs go straight to the pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot; gives 1 kHz per digit at 100 MHz. Legal range is >= 2.
- SCORE_W, 7: width of each binary score input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- score_l  input  SCORE_W  left player score, binary.
- score_r  input  SCORE_W  right player score, binary.
- load  input  1  request to convert and display score_l/score_r; sampled only while busy=0.
- busy  output  1  conversion in progress; load is ignored while high.
- tog  output  2  digit select to the BCD decoder.
- num  output  4  BCD digit value to the BCD decoder.
- frame_tick  output  1  one-cycle pulse when tog wraps from 3 to 0.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is asynchronous, active-low.
  - Reset values: state=IDLE, busy=0, refresh counter=0, tog=0, frame_tick=0, display buffer all 0 (so num=0).
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On the cycle it holds REFRESH_DIV-1, the next edge advances tog by 1 mod 4.
  - frame_tick is registered and is high for exactly one cycle, the cycle in which tog first shows 0 after a 3.
  - Scanning never stops. It is independent of busy.
- Digit map (num is a combinational mux of tog and the display buffer):
  - tog=0: right score, ones digit.
  - tog=1: right score, tens digit.
  - tog=2: left score, ones digit.
  - tog=3: left score, tens digit.
  - num is always in 0..9.
- Conversion FSM states: IDLE, CONV, COMMIT.
  - IDLE: if load=1 at an edge, capture both scores into shift registers, clear the BCD accumulators, set bit count=0, go to CONV, set busy=1. If a captured score is >99, saturate it to 99 at capture.
  - CONV: one double-dabble step per cycle, both scores in parallel.
    - First, for each BCD nibble >=5, add 3.
    - Then shift the {BCD, binary} register left by 1.
    - Run SCORE_W steps, then go to COMMIT.
  - COMMIT: on one edge, write all four BCD digits into the display buffer together (atomic update), go to IDLE, set busy=0.
- Latency: with load sampled at edge E0, the buffer updates at edge E(SCORE_W+1), which is E8 for default parameters. busy is high from after E0 until after E8. A new load can be accepted at E9.
- Boundary conditions:
  - load while busy=1: ignored; it is not queued.
  - Score inputs changing during CONV: no effect, because the values were already captured.
  - Buffer update landing at the same edge as a tog advance: both take effect. num shows the new buffer value for the new tog.
  - Partial conversion results are never visible on num.
  - Reset asserted mid-conversion: immediately return to reset values. The old buffer contents are discarded (cleared to 0).
  - load held high continuously: a conversion restarts every SCORE_W+2 cycles. Display stays consistent.

Test Plan:
All scenarios use REFRESH_DIV=4.
1. Reset release, no load: tog steps 0,1,2,3,0 every 4 cycles; num=0 throughout; frame_tick pulses once per 16 cycles; busy=0.
2. load with score_l=42, score_r=7: busy is high for 8 cycles. After commit, num is 7 at tog=0, 0 at tog=1, 2 at tog=2, 4 at tog=3.
3. load with score_l=120, score_r=99: saturation. Displays 9,9,9,9 for tog=0..3.
4. Second load pulsed 3 cycles after a first load of (10,5): the second load is ignored. Display shows 5,0,0,1. A third load of (3,3) after busy falls displays 3,0,3,0.
5. rst_n asserted at cycle 4 of CONV for load (55,66): outputs go to reset values asynchronously, busy=0, num=0. After release no commit occurs.
6. Sweep score_l from 0 to 99 with score_r=score_l: after each conversion the tens and ones digits match value/10 and value%10 at every tog, and no intermediate value appears on num.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: converts two binary scores to BCD with a
// sequential double-dabble and multiplexes the four digits onto tog/num.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int SCORE_W     = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score_l,
  input  logic [SCORE_W-1:0] score_r,
  input  logic               load,
  output logic               busy,
  output logic [1:0]         tog,
  output logic [3:0]         num,
  output logic               frame_tick
);

  //  state    | meaning
  //  S_IDLE   | waiting for load, display buffer stable
  //  S_CONV   | one double-dabble step per cycle on both scores
  //  S_COMMIT | copy all four BCD digits into the display buffer at once

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BIT_W = $clog2(SCORE_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SCORE_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_capture;
  logic               w_step;
  logic               w_commit;
  logic               w_busy;

  logic [CNT_W-1:0]   r_ref_cnt;
  logic [1:0]         r_tog;
  logic               r_frame_tick;
  logic               w_ref_wrap;

  logic [SCORE_W-1:0] r_bin_l;
  logic [SCORE_W-1:0] r_bin_r;
  logic [7:0]         r_bcd_l;
  logic [7:0]         r_bcd_r;
  logic [7:0]         w_adj_l;
  logic [7:0]         w_adj_r;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [3:0][3:0]    r_disp;

  function automatic logic [SCORE_W-1:0] f_sat(input logic [SCORE_W-1:0] s);
    if (int'(s) > 99) return SCORE_W'(99);
    return s;
  endfunction

  function automatic logic [7:0] f_adj(input logic [7:0] b);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
    hi = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
    return {hi, lo};
  endfunction

  assign w_adj_l = f_adj(r_bcd_l);
  assign w_adj_r = f_adj(r_bcd_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_capture   = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (r_bit_cnt == BIT_LAST) w_state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        w_busy      = 1'b1;
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin_l   <= '0;
      r_bin_r   <= '0;
      r_bcd_l   <= '0;
      r_bcd_r   <= '0;
      r_bit_cnt <= '0;
      r_disp    <= '0;
    end else begin
      if (w_capture) begin
        r_bin_l   <= f_sat(score_l);
        r_bin_r   <= f_sat(score_r);
        r_bcd_l   <= '0;
        r_bcd_r   <= '0;
        r_bit_cnt <= '0;
      end else if (w_step) begin
        {r_bcd_l, r_bin_l} <= {w_adj_l, r_bin_l} << 1;
        {r_bcd_r, r_bin_r} <= {w_adj_r, r_bin_r} << 1;
        r_bit_cnt          <= r_bit_cnt + 1'b1;
      end
      // Only the finished result ever reaches the buffer, all digits together.
      if (w_commit) begin
        r_disp[0] <= r_bcd_r[3:0];
        r_disp[1] <= r_bcd_r[7:4];
        r_disp[2] <= r_bcd_l[3:0];
        r_disp[3] <= r_bcd_l[7:4];
      end
    end
  end

  assign w_ref_wrap = (r_ref_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt    <= '0;
      r_tog        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_ref_wrap && (r_tog == 2'd3);
      if (w_ref_wrap) begin
        r_ref_cnt <= '0;
        r_tog     <= r_tog + 2'd1;
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
      end
    end
  end

  assign busy       = w_busy;
  assign tog        = r_tog;
  assign num        = r_disp[r_tog];
  assign frame_tick = r_frame_tick;

endmodule
